// File: rtl/vec_elem_sequencer_pkg.sv
// Shared types and helpers for the vector element-group sequencer.
// Holds the sequencer state encoding and the SEW decode used by the datapath.
package vec_elem_sequencer_pkg;

   localparam int IDX_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   // log2 of the element size in bytes (8/16/32/64 bits -> 0..3)
   function automatic logic [1:0] sew_lg2(input logic [6:0] sew);
      case (sew)
         7'd16:   return 2'd1;
         7'd32:   return 2'd2;
         7'd64:   return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/vec_elem_sequencer_mask_gen.sv
// Combinational beat decode: aligned beat start, next element index,
// byte enables of the active elements and the last-beat flag.
module vec_beat_mask_gen
   import vec_elem_sequencer_pkg::*;
#(
   parameter int DP_WIDTH = 64
)(
   input  logic [IDX_W-1:0]        idx,
   input  logic [IDX_W-1:0]        vl_eff,
   input  logic [1:0]              sew_lg,
   output logic [IDX_W-1:0]        bs,
   output logic [IDX_W:0]          nidx,
   output logic [DP_WIDTH/8-1:0]   beat_be,
   output logic                    beat_last
);
   localparam int DP_BYTES = DP_WIDTH / 8;

   logic [IDX_W:0] epb;

   // elements per beat is a power of two, so the beat start is a simple mask
   assign epb       = (IDX_W+1)'(DP_BYTES) >> sew_lg;
   assign bs        = idx & ~IDX_W'(epb - 1'b1);
   assign nidx      = {1'b0, bs} + epb;
   assign beat_last = (nidx >= {1'b0, vl_eff});

   always_comb begin
      logic [IDX_W:0] e;
      e       = '0;
      beat_be = '0;
      for (int b = 0; b < DP_BYTES; b++) begin
         e          = {1'b0, bs} + ((IDX_W+1)'(b) >> sew_lg);
         beat_be[b] = (e >= {1'b0, idx}) && (e < {1'b0, vl_eff});
      end
   end

endmodule

// File: rtl/vec_elem_sequencer.sv
// Element-group sequencer: latches the vector configuration per instruction
// and walks [vstart, min(vl, VLMAX)) one datapath beat per handshake.
module vec_elem_sequencer
   import vec_elem_sequencer_pkg::*;
#(
   parameter int VLEN     = 512,
   parameter int DP_WIDTH = 64,
   parameter int XLEN     = 32
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start_valid,
   output logic                             start_ready,
   input  logic [XLEN-1:0]                  cfg_vl,
   input  logic [XLEN-1:0]                  cfg_vstart,
   input  logic [6:0]                       cfg_sew,
   input  logic [4:0]                       cfg_vlmul,
   input  logic [9:0]                       cfg_vlmax,
   input  logic                             abort,
   output logic                             beat_valid,
   input  logic                             beat_ready,
   output logic [9:0]                       beat_elem_idx,
   output logic [DP_WIDTH/8-1:0]            beat_be,
   output logic [2:0]                       beat_vreg_off,
   output logic [$clog2(VLEN/DP_WIDTH)-1:0] beat_pos,
   output logic                             beat_last,
   output logic                             done,
   output logic                             vstart_clr,
   output logic                             vstart_wr_en,
   output logic [XLEN-1:0]                  vstart_wr_data
);
   localparam int DP_BYTES      = DP_WIDTH / 8;
   localparam int BEATS_PER_REG = VLEN / DP_WIDTH;
   localparam int POS_W         = $clog2(BEATS_PER_REG);
   localparam int DPB_LG        = $clog2(DP_BYTES);
   localparam int REG_LG        = $clog2(VLEN / 8);

   seq_state_e          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, vl_eff_q, vl_eff_in;
   logic [1:0]          sew_lg_q;
   logic [2:0]          grp_mask_q;
   logic [IDX_W-1:0]    bs;
   logic [IDX_W:0]      nidx;
   logic [DP_BYTES-1:0] be;
   logic                last, run, accept, hs, no_beats;
   logic [IDX_W+2:0]    ba;
   logic [2:0]          vreg_off;
   logic [POS_W-1:0]    pos;
   logic                wr_en_q;
   logic [XLEN-1:0]     wr_data_q;

   assign run       = (state_q == RUN);
   assign accept    = (state_q == IDLE) && start_valid;
   assign hs        = run && beat_ready;
   // clamp and range check at full XLEN so oversized vl/vstart behave
   assign vl_eff_in = (cfg_vl < XLEN'(cfg_vlmax)) ? IDX_W'(cfg_vl) : cfg_vlmax;
   assign no_beats  = (cfg_vstart >= XLEN'(vl_eff_in));

   vec_beat_mask_gen #(.DP_WIDTH(DP_WIDTH)) u_mask_gen (
      .idx       (idx_q),
      .vl_eff    (vl_eff_q),
      .sew_lg    (sew_lg_q),
      .bs        (bs),
      .nidx      (nidx),
      .beat_be   (be),
      .beat_last (last)
   );

   assign ba       = {3'b000, bs} << sew_lg_q;
   assign vreg_off = 3'(ba >> REG_LG) & grp_mask_q;
   assign pos      = POS_W'(ba >> DPB_LG);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_valid) state_d = no_beats ? DONE : RUN;
         RUN:     if (abort) state_d = IDLE;
                  else if (hs && last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // restart point reported on abort: past the beat if it was taken this cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= run && abort;
         if (run && abort) wr_data_q <= hs ? XLEN'(nidx) : XLEN'(idx_q);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q      <= IDX_W'(cfg_vstart);
         vl_eff_q   <= vl_eff_in;
         sew_lg_q   <= sew_lg2(cfg_sew);
         grp_mask_q <= 3'(cfg_vlmul - 5'd1);
      end else if (hs) begin
         idx_q <= nidx[IDX_W-1:0];
      end
   end

   assign start_ready    = (state_q == IDLE);
   assign beat_valid     = run;
   assign beat_elem_idx  = run ? idx_q : '0;
   assign beat_be        = run ? be : '0;
   assign beat_vreg_off  = run ? vreg_off : '0;
   assign beat_pos       = run ? pos : '0;
   assign beat_last      = run && last;
   assign done           = (state_q == DONE);
   assign vstart_clr     = (state_q == DONE);
   assign vstart_wr_en   = wr_en_q;
   assign vstart_wr_data = wr_data_q;

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Self-checking bench for vec_elem_sequencer: directed cases plus random
// instructions compared against an element-list reference model.
module tb_vec_elem_sequencer;
   localparam int VLEN     = 512;
   localparam int DP_WIDTH = 64;
   localparam int XLEN     = 32;
   localparam int POS_W    = $clog2(VLEN / DP_WIDTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             start_valid, start_ready;
   logic [XLEN-1:0]  cfg_vl, cfg_vstart;
   logic [6:0]       cfg_sew;
   logic [4:0]       cfg_vlmul;
   logic [9:0]       cfg_vlmax;
   logic             abort;
   logic             beat_valid, beat_ready;
   logic [9:0]       beat_elem_idx;
   logic [7:0]       beat_be;
   logic [2:0]       beat_vreg_off;
   logic [POS_W-1:0] beat_pos;
   logic             beat_last, done, vstart_clr, vstart_wr_en;
   logic [XLEN-1:0]  vstart_wr_data;

   always #5 clk = ~clk;

   vec_elem_sequencer #(.VLEN(VLEN), .DP_WIDTH(DP_WIDTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .cfg_vl(cfg_vl), .cfg_vstart(cfg_vstart), .cfg_sew(cfg_sew),
      .cfg_vlmul(cfg_vlmul), .cfg_vlmax(cfg_vlmax),
      .abort(abort),
      .beat_valid(beat_valid), .beat_ready(beat_ready),
      .beat_elem_idx(beat_elem_idx), .beat_be(beat_be),
      .beat_vreg_off(beat_vreg_off), .beat_pos(beat_pos), .beat_last(beat_last),
      .done(done), .vstart_clr(vstart_clr),
      .vstart_wr_en(vstart_wr_en), .vstart_wr_data(vstart_wr_data)
   );

   typedef struct {
      int idx;
      int nidx;
      int be;
      int off;
      int pos;
      bit last;
   } beat_t;

   beat_t exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   string cur = "reset";

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur, tag, got, exp);
      end
   endtask

   // Expected beats: walk the active elements, grouping them by aligned beat.
   task automatic build(input longint vl, input longint vstart, input int sew, input int vlmax);
      longint vl_eff;
      int sew_b, epb, i, bs, ba;
      beat_t bt;
      exp_q.delete();
      vl_eff = (vl < vlmax) ? vl : longint'(vlmax);
      sew_b  = sew / 8;
      epb    = 8 / sew_b;
      if (vstart >= vl_eff) return;
      i = int'(vstart);
      while (i < vl_eff) begin
         bs      = (i / epb) * epb;
         bt.idx  = i;
         bt.nidx = bs + epb;
         bt.be   = 0;
         for (int b = 0; b < 8; b++) begin
            int e;
            e = bs + b / sew_b;
            if (e >= i && e < vl_eff) bt.be |= (1 << b);
         end
         ba      = bs * sew_b;
         bt.off  = ba / (VLEN / 8);
         bt.pos  = (ba % (VLEN / 8)) / (DP_WIDTH / 8);
         bt.last = (bs + epb >= vl_eff);
         exp_q.push_back(bt);
         i = bs + epb;
      end
   endtask

   // mode 0: ready always high, 1: random ready, 2: alternating 1,0,1,...
   task automatic run_instr(input string name, input longint vl, input longint vstart,
                            input int sew, input int lmul, input int mode,
                            input int abort_at, input bit abort_rdy);
      int  vlmax, k, hs, budget;
      bit  rdy, phase, do_abort;
      logic [63:0] vl_v, vs_v;
      cur   = name;
      vlmax = VLEN * lmul / sew;
      build(vl, vstart, sew, vlmax);
      vl_v  = 64'(vl);
      vs_v  = 64'(vstart);
      @(negedge clk);
      check("start_ready_idle", start_ready, 1);
      start_valid = 1'b1;
      cfg_vl      = vl_v[31:0];
      cfg_vstart  = vs_v[31:0];
      cfg_sew     = 7'(sew);
      cfg_vlmul   = 5'(lmul);
      cfg_vlmax   = 10'(vlmax);
      abort       = 1'($urandom_range(0, 1));
      @(negedge clk);
      start_valid = 1'b0;
      abort       = 1'b0;
      cfg_vl      = $urandom;
      cfg_vstart  = $urandom;
      cfg_sew     = 7'(8 << $urandom_range(0, 3));
      cfg_vlmul   = 5'(1 << $urandom_range(0, 3));
      cfg_vlmax   = 10'($urandom);
      if (exp_q.size() == 0) begin
         check("nobeat_done", done, 1);
         check("nobeat_clr", vstart_clr, 1);
         check("nobeat_valid", beat_valid, 0);
         abort = 1'($urandom_range(0, 1));
         @(negedge clk);
         abort = 1'b0;
         check("nobeat_idle", start_ready, 1);
         check("nobeat_done_low", done, 0);
         check("nobeat_wr_en", vstart_wr_en, 0);
         return;
      end
      k = 0; hs = 0; budget = 0; phase = 1'b1;
      forever begin
         if (budget > 4 * exp_q.size() + 16) begin
            check("timeout", 1, 0);
            return;
         end
         check("beat_valid", beat_valid, 1);
         check("start_ready_busy", start_ready, 0);
         check("elem_idx", beat_elem_idx, 64'(exp_q[k].idx));
         check("be", beat_be, 64'(exp_q[k].be));
         check("vreg_off", beat_vreg_off, 64'(exp_q[k].off));
         check("pos", beat_pos, 64'(exp_q[k].pos));
         check("last", beat_last, 64'(exp_q[k].last));
         check("done_busy", done, 0);
         check("wr_en_busy", vstart_wr_en, 0);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 9) < 7);
            default: begin rdy = phase; phase = ~phase; end
         endcase
         do_abort = (k == abort_at);
         if (do_abort) begin
            rdy   = abort_rdy;
            abort = 1'b1;
         end
         beat_ready = rdy;
         @(negedge clk);
         abort      = 1'b0;
         beat_ready = 1'b0;
         if (do_abort) begin
            check("abort_wr_en", vstart_wr_en, 1);
            check("abort_wr_data", vstart_wr_data,
                  64'(rdy ? exp_q[k].nidx : exp_q[k].idx));
            check("abort_no_done", done, 0);
            check("abort_valid", beat_valid, 0);
            check("abort_idle", start_ready, 1);
            @(negedge clk);
            check("abort_wr_en_pulse", vstart_wr_en, 0);
            check("abort_no_done2", done, 0);
            return;
         end
         if (rdy) begin
            hs++;
            if (exp_q[k].last) break;
            k++;
         end
         budget++;
      end
      check("done", done, 1);
      check("vstart_clr", vstart_clr, 1);
      check("done_valid", beat_valid, 0);
      check("done_wr_en", vstart_wr_en, 0);
      check("handshakes", 64'(hs), 64'(exp_q.size()));
      abort = 1'($urandom_range(0, 1));
      @(negedge clk);
      abort = 1'b0;
      check("back_idle", start_ready, 1);
      check("done_pulse", done, 0);
      check("ignored_abort", vstart_wr_en, 0);
   endtask

   initial begin
      int sew, lmul, vlmax, r;
      longint vl, vs, vl_eff;
      rst = 1'b1; start_valid = 1'b0; abort = 1'b0; beat_ready = 1'b0;
      cfg_vl = '0; cfg_vstart = '0; cfg_sew = 7'd8; cfg_vlmul = 5'd1; cfg_vlmax = '0;
      #1;
      check("start_ready", start_ready, 1);
      check("beat_valid", beat_valid, 0);
      check("beat_last", beat_last, 0);
      check("done", done, 0);
      check("vstart_clr", vstart_clr, 0);
      check("wr_en", vstart_wr_en, 0);
      check("elem_idx", beat_elem_idx, 0);
      check("be", beat_be, 0);
      check("vreg_off", beat_vreg_off, 0);
      check("pos", beat_pos, 0);
      check("wr_data", vstart_wr_data, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_instr("sew32_vl10",     10,   0, 32, 1, 0, -1, 1'b0);
      run_instr("sew8_vs3",       13,   3,  8, 1, 0, -1, 1'b0);
      run_instr("sew64_lmul4",   100,   0, 64, 4, 0, -1, 1'b0);
      run_instr("vs_eq_vl",        7,   7, 32, 1, 0, -1, 1'b0);
      run_instr("sew16_toggle",   16,   0, 16, 1, 2, -1, 1'b0);
      run_instr("abort_rdy0",     16,   0, 32, 1, 0,  2, 1'b0);
      run_instr("abort_rdy1",     16,   0, 32, 1, 0,  2, 1'b1);
      run_instr("vs_huge",       300, 2000,  8, 8, 0, -1, 1'b0);
      run_instr("vl_huge", 64'hFFFF_FFF0, 5, 16, 2, 1, -1, 1'b0);

      for (int t = 0; t < 60; t++) begin
         sew   = 8 << $urandom_range(0, 3);
         lmul  = 1 << $urandom_range(0, 3);
         vlmax = VLEN * lmul / sew;
         r     = $urandom_range(0, 9);
         vl    = (r == 0) ? longint'($urandom) : longint'($urandom_range(0, vlmax + 16));
         vl_eff = (vl < vlmax) ? vl : longint'(vlmax);
         r     = $urandom_range(0, 9);
         if (r == 0)      vs = $urandom_range(1024, 5000);
         else if (r == 1) vs = vl_eff;
         else             vs = $urandom_range(0, int'(vl_eff));
         run_instr($sformatf("rand%0d", t), vl, vs, sew, lmul, 1,
                   ($urandom_range(0, 4) == 0) ? $urandom_range(0, 8) : -1,
                   1'($urandom_range(0, 1)));
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vec_elem_sequencer.md
# vec_elem_sequencer

Element-group sequencer that sits between the vector CSR register file and the vector execution datapath. On each accepted vector instruction it latches the current vector configuration (vl, vstart, SEW, LMUL, VLMAX). It then issues one datapath beat per cycle, under a valid/ready handshake, walking the active element range [vstart, min(vl, VLMAX)) of the register group. For each beat it provides the first element index, byte-enable mask, register-in-group and beat position. It reports completion so vstart is cleared, or, on abort, the element index to which vstart must be written.

## Interface
Parameters:
- VLEN, 512, vector register length in bits
- DP_WIDTH, 64, datapath beat width in bits; VLEN must be a multiple of DP_WIDTH
- XLEN, 32, scalar width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start_valid  in  1  instruction ready to sequence
- start_ready  out  1  sequencer idle, can accept
- cfg_vl  in  XLEN  vector length CSR value
- cfg_vstart  in  XLEN  vstart CSR value
- cfg_sew  in  7  decoded SEW: 8/16/32/64
- cfg_vlmul  in  5  decoded LMUL: 1/2/4/8
- cfg_vlmax  in  10  VLMAX for current vtype
- abort  in  1  trap/flush of in-flight instruction
- beat_valid  out  1  beat descriptor valid
- beat_ready  in  1  datapath accepts beat
- beat_elem_idx  out  10  index of first active element in beat
- beat_be  out  DP_WIDTH/8  byte enables of active elements
- beat_vreg_off  out  3  register within group (0..LMUL-1)
- beat_pos  out  $clog2(VLEN/DP_WIDTH)  beat position within register
- beat_last  out  1  final beat of instruction
- done  out  1  one-cycle completion pulse
- vstart_clr  out  1  clear vstart (with done)
- vstart_wr_en  out  1  one-cycle pulse on abort
- vstart_wr_data  out  XLEN  element index to restart from

## Operation
- States: IDLE, RUN, DONE. start_ready = (state==IDLE).
- IDLE: on start_valid, latch the configuration. vl_eff = min(cfg_vl, cfg_vlmax); idx = cfg_vstart.
  - If cfg_vstart >= vl_eff, go to DONE (no beats).
  - Otherwise go to RUN.
- RUN: beat_valid=1. Derived values:
  - Elements per beat: epb = DP_WIDTH/sew (8/4/2/1 at DP_WIDTH=64).
  - Beat start: bs = idx − (idx mod epb).
  - Next index: nidx = bs + epb.
  - beat_be: bytes of elements e with max(idx,bs) ≤ e < min(nidx, vl_eff) are set; all other bytes are 0.
  - Byte address: ba = bs*sew/8. beat_vreg_off = ba / (VLEN/8). beat_pos = (ba mod (VLEN/8)) / (DP_WIDTH/8).
  - beat_last = (nidx >= vl_eff).
- On the handshake (beat_valid && beat_ready): idx ← nidx. If beat_last, go to DONE.
- Without the handshake, all beat outputs stay stable.
- DONE: done=1 and vstart_clr=1 for one cycle, then go to IDLE.
- abort in RUN: go to IDLE. vstart_wr_en=1 for one cycle.
  - vstart_wr_data = nidx if a handshake occurs in the same cycle, otherwise idx.
  - done is not asserted.
  - abort in IDLE or DONE is ignored; done still pulses.
- Arithmetic: indices are 10-bit unsigned. vl and vstart are compared at XLEN width before truncation, so vstart ≥ 2^10 takes the no-beat path.
- Config inputs are sampled only on accept; later changes have no effect until the next instruction.

## Timing
- Reset values: state=IDLE, start_ready=1. beat_valid, beat_last, done, vstart_clr and vstart_wr_en are 0. beat_elem_idx, beat_be, beat_vreg_off, beat_pos and vstart_wr_data are 0.
- Accept in cycle N gives the first beat_valid in N+1. With beat_ready held high, one beat issues per cycle.
- done is asserted in the cycle after the last handshake. start_ready returns the cycle after done.
- No-beat case: done in N+1, idle in N+2.
- Beat outputs are registered state plus combinational decode of latched config. There is no combinational path from beat_ready to beat_valid.
- vstart_wr_en is asserted in the cycle after abort is sampled.

## Structure
- Add to vec_de_csr_defs.svh:
  - seq_state_e (IDLE/RUN/DONE).
  - Constants DP_BYTES and BEATS_PER_REG.
- Sub-module vec_beat_mask_gen: combinational; inputs idx, vl_eff, sew; outputs bs, nidx, beat_be, beat_last.
- The FSM, index register and abort logic stay in vec_elem_sequencer.

## Test plan
- SEW=32, LMUL=1, vl=10, vstart=0, ready=1 -> 5 beats with elem_idx 0,2,4,6,8, be=0xFF each, beat_last on the 5th; done one cycle later with vstart_clr.
- SEW=8, vl=13, vstart=3 -> beat 1: idx 3, be=0xF8; beat 2: idx 8, be=0x1F, last.
- SEW=64, LMUL=4, vl=100 (VLMAX=32) -> clamped to 32 beats; beat 8 has vreg_off=1, pos=0; the last beat has vreg_off=3, pos=7.
- vstart=7, vl=7 -> no beat_valid; done in the cycle after accept.
- SEW=16, vl=16, beat_ready toggled 1,0,1 -> outputs hold stable while ready is low; exactly 4 handshakes total.
- SEW=32, vl=16, abort asserted during the 3rd beat with ready=0 -> vstart_wr_en with data=4, no done, start_ready high next cycle. The same abort with ready=1 -> data=6.
